// File: rtl/aespim_reduce_accum.sv
// GF(2^(32*LIMBS)) MAC back end: XOR-accumulates 64-bit clmul products, folds mod x^(32*LIMBS)+POLY_LOW.
// Latency: last product to out_valid_o is LIMBS+1 cycles; with AESPIM_RACC_ZEROSKIP_EN it is 1 cycle when the upper half is zero.
// Backpressure: in_ready_o is low during fold and output; the result is held until out_ready_i.
module aespim_reduce_accum #(
   parameter int          LIMBS    = 4,
   parameter logic [31:0] POLY_LOW = 32'h0000_0087,
   localparam int         IDXW     = $clog2(2*LIMBS)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 flush_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [63:0]          in_product_i,
   input  logic [IDXW-1:0]      in_shift_idx_i,
   input  logic                 in_last_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [32*LIMBS-1:0]  out_data_o,
   output logic                 err_o
);

   localparam int NL = 2*LIMBS;

   typedef enum logic [1:0] {ST_ACC, ST_RED, ST_OUT} state_e;
   typedef logic [NL-1:0][31:0] acc_t;

   state_e          state_q, state_d;
   acc_t            acc_q, acc_d;
   logic [IDXW-1:0] cnt_q, cnt_d;
   logic            err_q, err_d;
   logic            in_ready_q, in_ready_d;
   logic            out_valid_q, out_valid_d;
   logic            xfer;
   logic            idx_ok;
   logic            upper_zero;
   logic [62:0]     fold_t;

   function automatic logic [62:0] clmul32(input logic [31:0] a, input logic [31:0] b);
      logic [62:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         if (b[i]) r = r ^ ({31'b0, a} << i);
      end
      return r;
   endfunction

   // in_ready_q is only high in ACC, so it doubles as the state qualifier.
   assign xfer   = in_valid_i && in_ready_q;
   assign idx_ok = (in_shift_idx_i <= IDXW'(NL-2));
   assign fold_t = clmul32(acc_q[cnt_q], POLY_LOW);

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      upper_zero  = 1'b0;

      if (flush_i) begin
         acc_d       = '0;
         cnt_d       = '0;
         err_d       = 1'b0;
         state_d     = ST_ACC;
         in_ready_d  = 1'b1;
         out_valid_d = 1'b0;
      end else begin
         case (state_q)
            ST_ACC: begin
               if (xfer) begin
                  if (idx_ok) begin
                     for (int i = 0; i < NL; i++) begin
                        if (i == int'(in_shift_idx_i))
                           acc_d[i] = acc_d[i] ^ in_product_i[31:0];
                        if (i == int'(in_shift_idx_i) + 1)
                           acc_d[i] = acc_d[i] ^ in_product_i[63:32];
                     end
                  end else begin
                     err_d = 1'b1;
                  end
                  if (in_last_i) begin
`ifdef AESPIM_RACC_ZEROSKIP_EN
                     upper_zero = 1'b1;
                     for (int i = LIMBS; i < NL; i++) begin
                        if (acc_d[i] != 32'h0) upper_zero = 1'b0;
                     end
`endif
                     in_ready_d = 1'b0;
                     if (upper_zero) begin
                        state_d     = ST_OUT;
                        out_valid_d = 1'b1;
                     end else begin
                        state_d = ST_RED;
                        cnt_d   = IDXW'(NL-1);
                     end
                  end
               end
            end

            ST_RED: begin
               // Descending order lets spill into limb LIMBS be folded later in this pass.
               for (int i = 0; i < NL; i++) begin
                  if (i == int'(cnt_q))
                     acc_d[i] = 32'h0;
                  if (i == int'(cnt_q) - LIMBS)
                     acc_d[i] = acc_d[i] ^ fold_t[31:0];
                  if (i == int'(cnt_q) - LIMBS + 1)
                     acc_d[i] = acc_d[i] ^ {1'b0, fold_t[62:32]};
               end
               if (cnt_q == IDXW'(LIMBS)) begin
                  state_d     = ST_OUT;
                  out_valid_d = 1'b1;
               end else begin
                  cnt_d = cnt_q - IDXW'(1);
               end
            end

            ST_OUT: begin
               if (out_ready_i) begin
                  acc_d       = '0;
                  state_d     = ST_ACC;
                  in_ready_d  = 1'b1;
                  out_valid_d = 1'b0;
               end
            end

            default: begin
               acc_d       = '0;
               cnt_d       = '0;
               state_d     = ST_ACC;
               in_ready_d  = 1'b1;
               out_valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_ACC;
         acc_q       <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign err_o       = err_q;
   assign out_data_o  = acc_q[LIMBS-1:0];

endmodule

// File: tb/tb_aespim_reduce_accum.sv
// Directed bench for aespim_reduce_accum with LIMBS=4, POLY_LOW=0x87.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_aespim_reduce_accum;

   logic         clk;
   logic         rst_n;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic [63:0]  in_product;
   logic [2:0]   in_shift_idx;
   logic         in_last;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         err;

   int checks   = 0;
   int failures = 0;

`ifdef AESPIM_RACC_ZEROSKIP_EN
   localparam int LAT_SKIP = 1;
`else
   localparam int LAT_SKIP = 5;
`endif
   localparam int LAT_FULL = 5;

   aespim_reduce_accum #(.LIMBS(4), .POLY_LOW(32'h0000_0087)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .flush_i        (flush),
      .in_valid_i     (in_valid),
      .in_ready_o     (in_ready),
      .in_product_i   (in_product),
      .in_shift_idx_i (in_shift_idx),
      .in_last_i      (in_last),
      .out_valid_o    (out_valid),
      .out_ready_i    (out_ready),
      .out_data_o     (out_data),
      .err_o          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic do_xfer(input logic [63:0] p, input logic [2:0] idx, input logic last);
      @(negedge clk);
      in_valid     = 1'b1;
      in_product   = p;
      in_shift_idx = idx;
      in_last      = last;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Returns the cycle (relative to the accepting edge) in which out_valid is first seen.
   task automatic wait_out(output int lat);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 60) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic take_out();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_data !== 128'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      int lat;
      do_xfer(64'h1, 3'd0, 1'b1);
      wait_out(lat);
      checks++; if (lat != LAT_SKIP) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", lat, LAT_SKIP); end
      checks++; if (out_data !== 128'h1) begin failures++; $display("FAIL single_data got=%h exp=%h", out_data, 128'h1); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL single_err got=%b exp=0", err); end
      take_out();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL single_return got=%b%b exp=10", in_ready, out_valid); end
   endtask

   task automatic test_x128();
      int lat;
      do_xfer(64'h1_0000_0000, 3'd3, 1'b1);
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL x128_busy got=%b exp=0", in_ready); end
      wait_out(lat);
      checks++; if (lat != LAT_FULL) begin failures++; $display("FAIL x128_latency got=%0d exp=%0d", lat, LAT_FULL); end
      checks++; if (out_data !== 128'h87) begin failures++; $display("FAIL x128_data got=%h exp=%h", out_data, 128'h87); end
      take_out();
   endtask

   task automatic test_double_fold();
      int lat;
      do_xfer(64'hFFFF_FFFF_0000_0000, 3'd6, 1'b0);
      do_xfer(64'h5, 3'd0, 1'b1);
      wait_out(lat);
      checks++; if (lat != LAT_FULL) begin failures++; $display("FAIL dfold_latency got=%0d exp=%0d", lat, LAT_FULL); end
      checks++; if (out_data !== 128'h0000007D_00000000_00000000_00003FF6) begin
         failures++; $display("FAIL dfold_data got=%h exp=%h", out_data, 128'h0000007D_00000000_00000000_00003FF6); end
      take_out();
   endtask

   task automatic test_back_to_back();
      int lat;
      @(negedge clk);
      in_valid = 1'b1; in_product = 64'h0000_0011_0000_0022; in_shift_idx = 3'd0; in_last = 1'b0;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready1 got=%b exp=1", in_ready); end
      in_product = 64'h0000_0000_0000_0033; in_shift_idx = 3'd1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready2 got=%b exp=1", in_ready); end
      in_product = 64'h0000_0044_0000_0000; in_shift_idx = 3'd2; in_last = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_busy got=%b exp=0", in_ready); end
      wait_out(lat);
      checks++; if (lat != LAT_SKIP) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, LAT_SKIP); end
      checks++; if (out_data !== 128'h00000044_00000000_00000022_00000022) begin
         failures++; $display("FAIL b2b_data got=%h exp=%h", out_data, 128'h00000044_00000000_00000022_00000022); end
      take_out();
   endtask

   task automatic test_hold();
      int lat;
      logic [127:0] exp;
      exp = 128'h00000000_00000000_DEADBEEF_00000000;
      do_xfer(64'h0000_0000_DEAD_BEEF, 3'd1, 1'b1);
      wait_out(lat);
      checks++; if (lat != LAT_SKIP) begin failures++; $display("FAIL hold_latency got=%0d exp=%0d", lat, LAT_SKIP); end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checks++;
         if ({out_valid, in_ready, out_data} !== {1'b1, 1'b0, exp}) begin
            failures++; $display("FAIL hold_cycle%0d got=%b%b_%h exp=10_%h", c, out_valid, in_ready, out_data, exp);
         end
      end
      take_out();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL hold_release got=%b%b exp=10", in_ready, out_valid); end
   endtask

   task automatic test_drop_err();
      int lat;
      do_xfer(64'h1234, 3'd7, 1'b1);
      wait_out(lat);
      checks++; if (lat != LAT_SKIP) begin failures++; $display("FAIL drop_latency got=%0d exp=%0d", lat, LAT_SKIP); end
      checks++; if (out_data !== 128'h0) begin failures++; $display("FAIL drop_data got=%h exp=0", out_data); end
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL drop_err got=%b exp=1", err); end
      take_out();
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL drop_err_sticky got=%b exp=1", err); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL drop_return got=%b exp=1", in_ready); end
   endtask

   task automatic test_rst_mid_red();
      int lat;
      do_xfer(64'h0000_0001_0000_00AB, 3'd3, 1'b1);
      @(posedge clk);
      #2;
      checks++; if (out_data !== 128'h000000AB_00000000_00000000_00000000 || in_ready !== 1'b0) begin
         failures++; $display("FAIL rst_pre got=%b_%h exp=0_%h", in_ready, out_data, 128'h000000AB_00000000_00000000_00000000); end
      rst_n = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_async_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_async_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_data !== 128'h0) begin failures++; $display("FAIL rst_async_data got=%h exp=0", out_data); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_async_err got=%b exp=0", err); end
      @(negedge clk);
      rst_n = 1'b1;
      do_xfer(64'h2, 3'd1, 1'b1);
      wait_out(lat);
      checks++; if (lat != LAT_SKIP) begin failures++; $display("FAIL rst_fresh_latency got=%0d exp=%0d", lat, LAT_SKIP); end
      checks++; if (out_data !== 128'h00000000_00000000_00000002_00000000) begin
         failures++; $display("FAIL rst_fresh_data got=%h exp=%h", out_data, 128'h00000000_00000000_00000002_00000000); end
      take_out();
   endtask

   task automatic test_flush();
      int lat;
      do_xfer(64'h55, 3'd7, 1'b0);
      checks++; if (err !== 1'b1 || in_ready !== 1'b1) begin failures++; $display("FAIL flush_pre got=%b%b exp=11", err, in_ready); end
      do_xfer(64'h0000_0001_0000_00AB, 3'd3, 1'b1);
      @(negedge clk);
      flush = 1'b1;
      in_valid = 1'b1; in_product = 64'hFF; in_shift_idx = 3'd0; in_last = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      in_valid = 1'b0; in_last = 1'b0;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL flush_state got=%b%b exp=10", in_ready, out_valid); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL flush_err got=%b exp=0", err); end
      checks++; if (out_data !== 128'h0) begin failures++; $display("FAIL flush_data got=%h exp=0", out_data); end
      // A transfer coincident with flush in ACC must be ignored.
      flush = 1'b1;
      in_valid = 1'b1; in_product = 64'hFF; in_shift_idx = 3'd0; in_last = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      in_valid = 1'b0; in_last = 1'b0;
      checks++; if (in_ready !== 1'b1 || out_data !== 128'h0) begin failures++; $display("FAIL flush_xfer_ignored got=%b_%h exp=1_0", in_ready, out_data); end
      do_xfer(64'h3, 3'd0, 1'b1);
      wait_out(lat);
      checks++; if (lat != LAT_SKIP) begin failures++; $display("FAIL flush_fresh_latency got=%0d exp=%0d", lat, LAT_SKIP); end
      checks++; if (out_data !== 128'h3) begin failures++; $display("FAIL flush_fresh_data got=%h exp=%h", out_data, 128'h3); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL flush_fresh_err got=%b exp=0", err); end
      take_out();
   endtask

   initial begin
      rst_n        = 1'b0;
      flush        = 1'b0;
      in_valid     = 1'b0;
      in_product   = '0;
      in_shift_idx = '0;
      in_last      = 1'b0;
      out_ready    = 1'b0;
      test_reset();
      test_single();
      test_x128();
      test_double_fold();
      test_back_to_back();
      test_hold();
      test_drop_err();
      test_rst_mid_red();
      test_flush();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/aespim_reduce_accum.md
# aespim_reduce_accum

Streaming GF(2^(32·LIMBS)) multiply-accumulate back end for the aespim datapath. It takes 64-bit carry-less partial products, each tagged with a 32-bit limb offset, and XOR-accumulates them into an unreduced 2·LIMBS-limb register. After the last product it folds the upper limbs modulo x^(32·LIMBS) + POLY_LOW(x), one limb per cycle, and returns the reduced field element over a valid/ready handshake. It sits between the clmul array and the GHASH/PIM result path.

## Interface
- LIMBS, default 4: number of 32-bit limbs in a field element; must be ≥ 2 (default gives 128 bits).
- POLY_LOW, default 32'h0000_0087: low part R(x) of the reduction polynomial, with an implicit x^(32·LIMBS) term; degree ≤ 31.
- Derived IDXW = $clog2(2·LIMBS).
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous clear; highest priority after reset.
- in_valid_i  in  1  product valid.
- in_ready_o  out  1  block accepts a product.
- in_product_i  in  64  carry-less partial product.
- in_shift_idx_i  in  IDXW  limb offset; legal range 0..2·LIMBS-2.
- in_last_i  in  1  final product of the current element.
- out_valid_o  out  1  reduced result valid.
- out_ready_i  in  1  consumer accepts the result.
- out_data_o  out  32·LIMBS  reduced result.
- err_o  out  1  sticky: at least one out-of-range shift index was dropped.

## Operation
- Register acc holds limbs 0..2·LIMBS-1, each 32 bits. The FSM has three states: ACC, RED and OUT.
- ACC state:
  - in_ready_o = 1. A transfer occurs when in_valid_i and in_ready_o are both high.
  - On a transfer with idx ≤ 2·LIMBS-2: limb[idx] ^= product[31:0] and limb[idx+1] ^= product[63:32].
  - On a transfer with idx > 2·LIMBS-2: the product is dropped and err_o is set to 1.
  - A transfer with in_last_i = 1 moves the FSM to RED with cnt = 2·LIMBS-1. This applies even if that product was dropped.
- RED state:
  - in_ready_o = 0.
  - Each cycle: L = limb[cnt]; T = clmul(L, POLY_LOW), 63 bits.
  - Updates: limb[cnt] ← 0, limb[cnt-LIMBS] ^= T[31:0], limb[cnt-LIMBS+1] ^= T[62:32].
  - Then cnt decrements. After the cnt = LIMBS fold, the FSM moves to OUT.
  - Limbs are folded in descending order, so spill into limb LIMBS is folded later in the same pass.
- OUT state:
  - out_valid_o = 1 and out_data_o = limbs LIMBS-1..0, concatenated with the MSB limb first.
  - When out_ready_i = 1, acc is cleared and the FSM returns to ACC. err_o is not cleared by this.
- flush_i: clears acc, cnt and err_o and forces ACC, dropping any pending output. A transfer presented in the same cycle as flush_i is ignored.
- Reset values: in_ready_o = 1, out_valid_o = 0, out_data_o = 0, err_o = 0, state ACC.

## Timing
- Product accepted with last at cycle t, macro undefined:
  - RED occupies cycles t+1..t+LIMBS.
  - out_valid_o rises at t+LIMBS+1.
- Throughput is one product per cycle in ACC.
- out_data_o is held stable while out_valid_o = 1 and out_ready_i = 0.
- Earliest next transfer is the cycle after the output handshake, because in_ready_o is state-decoded and has no combinational path from out_ready_i.
- A reset assertion in any state returns all outputs to their reset values immediately, without waiting for a clock edge.

## Configuration
- AESPIM_RACC_ZEROSKIP_EN:
  - Defined: on the last-transfer edge, if limbs LIMBS..2·LIMBS-1 are all zero after the update, the FSM goes straight to OUT. out_valid_o then rises at t+1.
  - Undefined: RED always runs all LIMBS cycles, giving fixed latency.

## Test plan
- LIMBS=4: product 64'h1, idx 0, last → out_data_o = 128'h1, with out_valid_o at t+5 (macro off) or t+1 (macro on).
- Product 64'h1_0000_0000, idx 3, last (represents x^128) → out_data_o = 128'h87 at t+5, regardless of the macro.
- Products 64'hFFFF_FFFF_0000_0000 at idx 6, then 64'h5 at idx 0 with last → out_data_o matches the reference-model reduction, including the double fold through limb 4.
- idx 7 with product 64'h1234 and last → product dropped, err_o = 1, out_data_o = 0, err_o persists across the output handshake.
- Hold out_ready_i = 0 for 10 cycles in OUT → out_data_o stable and in_ready_o = 0. Then assert out_ready_i → ACC on the next cycle.
- Pulse rst_ni low during RED cycle 2 → outputs take their reset values immediately and a fresh product reduces correctly. Repeat with flush_i instead and check err_o = 0 afterwards.
